// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave frame engine: one-hot state codes,
// command encodings and the frame width derivation.
package spi_slave_pkg;

    localparam logic [4:0] ST_IDLE      = 5'b00001;
    localparam logic [4:0] ST_CHK_CMD   = 5'b00010;
    localparam logic [4:0] ST_WRITE     = 5'b00100;
    localparam logic [4:0] ST_READ_ADD  = 5'b01000;
    localparam logic [4:0] ST_READ_DATA = 5'b10000;

    typedef enum logic [4:0] {
        IDLE      = ST_IDLE,
        CHK_CMD   = ST_CHK_CMD,
        WRITE     = ST_WRITE,
        READ_ADD  = ST_READ_ADD,
        READ_DATA = ST_READ_DATA
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Frame = two command bits followed by the payload.
    function automatic int frame_w(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/spi_slave_frame_tx.sv
// Parallel-in serial-out MISO shifter. serial_out is registered: the MSB
// appears the cycle after load, then one bit per cycle down to bit 0, then
// the line returns to IDLE_MISO. abort drops the line to idle next cycle.
module spi_tx_shifter
    import spi_slave_pkg::*;
#(
    parameter int   DATA_W    = 8,
    parameter logic IDLE_MISO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] parallel_in,
    input  logic              abort,
    output logic              serial_out,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sreg;
    logic [CW-1:0]     cnt;  // bits still to present, including the one on the line

    assign busy = (cnt != '0);

    // Load, shift out MSB first, and return to idle after the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg       <= '0;
            cnt        <= '0;
            serial_out <= IDLE_MISO;
        end else if (abort) begin
            cnt        <= '0;
            serial_out <= IDLE_MISO;
        end else if (load) begin
            sreg       <= parallel_in << 1;
            serial_out <= parallel_in[DATA_W-1];
            cnt        <= CW'(DATA_W);
        end else if (cnt > CW'(1)) begin
            serial_out <= sreg[DATA_W-1];
            sreg       <= sreg << 1;
            cnt        <= cnt - CW'(1);
        end else if (cnt == CW'(1)) begin
            serial_out <= IDLE_MISO;
            cnt        <= '0;
        end
    end

endmodule

// File: rtl/spi_slave_frame.sv
// SPI slave frame engine: deserialises {cmd[1:0], payload} frames from MOSI,
// tracks read-address/read-data sequencing and serialises RAM read data on
// MISO. Define SPI_FRAME_ERR_EN to add the frame_err abort indication.
module spi_slave_frame
    import spi_slave_pkg::*;
#(
    parameter int   DATA_W    = 8,
    parameter logic IDLE_MISO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int FRAME_W = frame_w(DATA_W);
    localparam int CW      = $clog2(FRAME_W + 1);

    state_t             cs;
    logic [CW-1:0]      cnt;           // frame bits captured so far
    logic [FRAME_W-2:0] sr;            // all but the final bit of the frame
    logic               rd_addr_seen;
    logic               tx_loaded;     // one MISO load per READ_DATA frame
    logic               tx_busy;
    logic               tx_load;

    // Read data is accepted only once the READ_DATA frame is fully captured.
    assign tx_load = (cs == READ_DATA) && (cnt == CW'(FRAME_W)) && !tx_loaded
                     && !tx_busy && !SS_n && tx_valid;

    // Frame FSM, rx capture and read sequencing flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs           <= IDLE;
            cnt          <= '0;
            sr           <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
            tx_loaded    <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err    <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
            frame_err <= SS_n && ((cs != IDLE && cnt != CW'(FRAME_W)) || tx_busy);
`endif
            if (SS_n) begin
                cs        <= IDLE;
                cnt       <= '0;
                sr        <= '0;
                tx_loaded <= 1'b0;
            end else begin
                if (tx_load)
                    tx_loaded <= 1'b1;
                case (cs)
                    IDLE: begin
                        cs  <= CHK_CMD;
                        cnt <= '0;
                        sr  <= '0;
                    end
                    CHK_CMD: begin
                        sr  <= {{(FRAME_W-2){1'b0}}, MOSI};
                        cnt <= CW'(1);
                        if (MOSI == CMD_WR_ADDR[1])
                            cs <= WRITE;
                        else if (rd_addr_seen)
                            cs <= READ_DATA;
                        else
                            cs <= READ_ADD;
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (cnt != CW'(FRAME_W)) begin
                            sr  <= {sr[FRAME_W-3:0], MOSI};
                            cnt <= cnt + CW'(1);
                            if (cnt == CW'(FRAME_W - 1)) begin
                                rx_valid <= 1'b1;
                                rx_data  <= {sr, MOSI};
                                if (cs == READ_ADD)
                                    rd_addr_seen <= 1'b1;
                                else if (cs == READ_DATA)
                                    rd_addr_seen <= 1'b0;
                            end
                        end
                    end
                    default: cs <= IDLE;
                endcase
            end
        end
    end

    spi_tx_shifter #(.DATA_W(DATA_W), .IDLE_MISO(IDLE_MISO)) u_tx (
        .clk         (clk),
        .rst         (rst),
        .load        (tx_load),
        .parallel_in (tx_data),
        .abort       (SS_n),
        .serial_out  (MISO),
        .busy        (tx_busy)
    );

endmodule

// File: tb/tb_spi_slave_frame.sv
// Self-checking bench for spi_slave_frame: frame-level reference model
// compared every cycle, directed literal checks, randomized frames, and a
// second DATA_W=12 instance for the wide-frame case.
module tb_spi_slave_frame;
    import spi_slave_pkg::*;

    localparam int   DW     = 8;
    localparam int   FW     = DW + 2;
    localparam logic IDLE_M = 1'b0;
    localparam int   K_WR = 0, K_RA = 1, K_RD = 2;

    logic          clk = 1'b0, rst = 1'b1, SS_n = 1'b1, MOSI = 1'b0, tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          MISO, rx_valid;
    logic [FW-1:0] rx_data;

    logic          ss12 = 1'b1, mosi12 = 1'b0, txv12 = 1'b0;
    logic [11:0]   txd12 = '0;
    logic          miso12, rxv12;
    logic [13:0]   rxd12;
`ifdef SPI_FRAME_ERR_EN
    logic          frame_err, frame_err12;
`endif

    spi_slave_frame #(.DATA_W(DW), .IDLE_MISO(IDLE_M)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .tx_data(tx_data),
        .tx_valid(tx_valid), .MISO(MISO), .rx_data(rx_data), .rx_valid(rx_valid)
`ifdef SPI_FRAME_ERR_EN
        , .frame_err(frame_err)
`endif
    );

    spi_slave_frame #(.DATA_W(12), .IDLE_MISO(1'b0)) dut12 (
        .clk(clk), .rst(rst), .SS_n(ss12), .MOSI(mosi12), .tx_data(txd12),
        .tx_valid(txv12), .MISO(miso12), .rx_data(rxd12), .rx_valid(rxv12)
`ifdef SPI_FRAME_ERR_EN
        , .frame_err(frame_err12)
`endif
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the frame, captured value, and a queue
    // of MISO bits still to appear (head = bit currently on the line).
    bit            started = 0;
    int            pos = -1;
    int            kind = K_WR;
    logic [FW-1:0] mframe = '0;
    logic          m_rxv = 1'b0, m_err = 1'b0;
    logic [FW-1:0] m_rxd = '0;
    bit            rd_seen = 0, loaded = 0;
    bit            q[$];

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            pos = -1; m_rxv = 0; m_rxd = '0; rd_seen = 0; loaded = 0; m_err = 0;
            q.delete();
        end else begin
            m_rxv = 0;
            m_err = SS_n && ((pos >= 0 && pos < FW) || q.size() != 0);
            if (SS_n) q.delete();
            else if (q.size() != 0) void'(q.pop_front());
            if (!SS_n && kind == K_RD && pos == FW && !loaded && tx_valid) begin
                loaded = 1;
                for (int i = DW-1; i >= 0; i--) q.push_back(tx_data[i]);
            end
            if (SS_n) begin
                pos = -1; loaded = 0;
            end else if (pos < 0) begin
                pos = 0;
            end else if (pos < FW) begin
                if (pos == 0) kind = !MOSI ? K_WR : (rd_seen ? K_RD : K_RA);
                mframe = {mframe[FW-2:0], MOSI};
                pos++;
                if (pos == FW) begin
                    m_rxv = 1; m_rxd = mframe;
                    if (kind == K_RA) rd_seen = 1;
                    else if (kind == K_RD) rd_seen = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model rx_valid", rx_valid, m_rxv);
            chk("model rx_data", rx_data, m_rxd);
            chk("model MISO", MISO, (q.size() != 0) ? q[0] : IDLE_M);
`ifdef SPI_FRAME_ERR_EN
            chk("model frame_err", frame_err, m_err);
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic select();
        SS_n = 1'b0;
        tick();
    endtask

    task automatic deselect();
        SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0;
        tick();
    endtask

    task automatic shift_bits(input logic [FW-1:0] f, input int n);
        for (int i = FW-1; i >= FW-n; i--) begin
            MOSI = f[i];
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] got;
        logic [FW-1:0] f;
        logic [13:0]   f12;
        int            nb;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("reset rx_valid", rx_valid, 0);
        chk("reset rx_data", rx_data, 0);
        chk("reset MISO", MISO, IDLE_M);
        chk("reset cs", dut.cs, IDLE);

        // Write frame 00_10100101
        select();
        shift_bits(10'b00_1010_0101, FW);
        chk("wr rx_valid", rx_valid, 1);
        chk("wr rx_data", rx_data, 10'h0A5);
        chk("wr cs", dut.cs, WRITE);
        tick();
        chk("wr pulse width", rx_valid, 0);
        deselect();
        chk("wr idle", dut.cs, IDLE);

        // Read address then read data with MISO return
        select();
        shift_bits({CMD_RD_ADDR, 8'h0F}, FW);
        chk("ra rx_data", rx_data, 10'h20F);
        deselect();
        select();
        shift_bits({CMD_RD_DATA, 8'h00}, FW);
        chk("rd rx_data", rx_data, 10'h300);
        chk("rd cs", dut.cs, READ_DATA);
        tx_data = 8'hC3; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = DW-1; i >= 0; i--) begin
            got[i] = MISO;
            tick();
        end
        chk("rd MISO byte", got, 8'hC3);
        chk("rd MISO idle", MISO, IDLE_M);
        deselect();
        // rd_addr_seen was cleared: the next read command is an address
        select();
        shift_bits({CMD_RD_ADDR, 8'h55}, 3);
        chk("seen cleared cs", dut.cs, READ_ADD);
        deselect();

        // Read command after reset enters READ_ADD
        rst = 1'b1; tick(); rst = 1'b0;
        select();
        shift_bits({CMD_RD_DATA, 8'h11}, FW);
        chk("after reset cs", dut.cs, READ_ADD);
        deselect();
        select();
        shift_bits({CMD_RD_DATA, 8'h22}, 2);
        chk("second read cs", dut.cs, READ_DATA);
        deselect();

        // Abort after 5 bits of a write frame
        select();
        shift_bits({CMD_WR_DATA, 8'hFF}, FW);
        deselect();
        select();
        shift_bits({CMD_WR_ADDR, 8'h3C}, 5);
        SS_n = 1'b1; MOSI = 1'b0;
        tick();
        chk("abort rx_valid", rx_valid, 0);
        chk("abort rx_data", rx_data, 10'h1FF);
        chk("abort cs", dut.cs, IDLE);
`ifdef SPI_FRAME_ERR_EN
        chk("abort frame_err", frame_err, 1);
        tick();
        chk("abort frame_err pulse", frame_err, 0);
`endif

        // Reset during bit 6 of a read-address frame
        select();
        shift_bits({CMD_RD_ADDR, 8'hAA}, 6);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid rst rx_data", rx_data, 0);
        chk("mid rst cs", dut.cs, IDLE);
        deselect();
        select();
        shift_bits({CMD_RD_DATA, 8'hAA}, 2);
        chk("mid rst next cs", dut.cs, READ_ADD);
        deselect();

        // Randomized frames against the model
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end
            f  = FW'($urandom);
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, FW-1) : FW;
            select();
            shift_bits(f, nb);
            if (nb == FW) begin
                repeat ($urandom_range(0, 14)) begin
                    tx_valid = 1'($urandom_range(0, 1));
                    tx_data  = DW'($urandom);
                    MOSI     = 1'($urandom);
                    rst      = ($urandom_range(0, 60) == 0);
                    tick();
                    rst = 1'b0;
                end
                tx_valid = 1'b0;
            end
            deselect();
            repeat ($urandom_range(0, 2)) tick();
        end

        // Wide frame on the DATA_W=12 instance: 01_ABC
        f12 = 14'h1ABC;
        ss12 = 1'b0;
        tick();
        for (int i = 13; i >= 0; i--) begin
            if (i == 0) chk("w12 no early valid", rxv12, 0);
            mosi12 = f12[i];
            tick();
        end
        chk("w12 rx_valid", rxv12, 1);
        chk("w12 rx_data", rxd12, 14'h1ABC);
        chk("w12 MISO", miso12, 0);
        ss12 = 1'b1;
        tick();
        chk("w12 pulse width", rxv12, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
